ctrl_pipe_gen: RTL and testbench
================================

// Module: ctrl_pipe_gen
// PURPOSE
//  Parametrised control-propagation pipeline for the ARM-style core. Takes decoded control bundles
//  from Decode and carries them through E and N_POST further stages. In E it evaluates the 4-bit
//  condition and updates the architectural flags register. It gates side-effecting controls and
//  reports pending PC writes. Sits between the decoder and the hazard unit / datapath.
// PARAMETERS
//  CTRL_W  8  width of opaque control bundle carried unmodified (ALUSrc, MemtoReg, mem-mode bits, ...)
//  RW_W    2  register-write code width (00 none, 01 32-bit, 11 64-bit pair)
//  FLAG_W  5  flags width, MSB..LSB = {N,Z,C,V,Q}; FLAG_W>=4, bits above V are "extended"
//  N_POST  2  stages after E (>=2); stage 1 = M, stage N_POST = W
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous active-high reset
//  validD       in   1       D slot holds a real instruction
//  ctrlD        in   CTRL_W  opaque control bundle
//  reg_writeD   in   RW_W    register-write code
//  mem_writeD   in   1       store
//  branchD      in   1       branch
//  pc_writeD    in   1       instruction writes PC (Rd==PC or branch)
//  no_writeD    in   1       compare/test: suppress reg write
//  flag_writeD  in   2       [1]=update N,Z  [0]=update C,V and extended bits
//  condD        in   4       ARM condition field
//  alu_flagsE   in   FLAG_W  flags produced by ALU for the E instruction
//  flushE       in   1       bubble E on next edge
//  stallE       in   1       hold E (active only with CTRL_PIPE_STALL_EN)
//  ctrlE        out  CTRL_W  E-stage bundle
//  cond_exE     out  1       E condition passed and E valid
//  branch_takenE out 1       branchE & cond_exE
//  flagsE       out  FLAG_W  architectural flags register
//  ctrlM/ctrlW  out  CTRL_W  bundle at stage 1 / stage N_POST
//  reg_writeM/W out  RW_W    gated reg-write at stage 1 / N_POST
//  mem_writeM   out  1       gated store at stage 1
//  pc_srcW      out  1       gated PC write at stage N_POST
//  pc_wr_pendingF out 1      OR of pc_write over D (validD) and every valid stage E..N_POST
// BEHAVIOUR
//  - Reset (async): all stage registers and valids 0, flagsE 0, every output 0.
//  - D->E register: loads D fields each edge. flushE loads a bubble (valid=0, all controls 0).
//    flushE beats stallE.
//  - Condition: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL on flagsE (N,Z,C,V).
//    Code 1111 is treated as AL. cond_exE = validE & pass.
//  - Flags: on an edge with cond_exE and not stalled, flag_write[1] loads N,Z from alu_flagsE;
//    flag_write[0] loads C,V and bits [FLAG_W-5:0]. Otherwise hold. Latency 1 cycle: the next E sees new flags.
//  - Gating into stage 1: reg_write = (cond_exE & ~no_write) ? code : 0; mem_write, pc_write,
//    branch ANDed with cond_exE. ctrl passes ungated.
//  - Stages 1..N_POST form a plain shift chain, 1 cycle per stage, no enables. Latency E->W = N_POST cycles.
//  - Back-to-back flag writers: the second evaluates its condition on the first's result (no stale read).
//  - Bubble in E (flush or stall) inserts all-zero controls into stage 1.
// CONFIGURATION
//  CTRL_PIPE_STALL_EN defined: stallE=1 holds the E register and flagsE.
//    A bubble enters stage 1, and cond_exE/branch_takenE are forced 0 while stalled.
//  Not defined: stallE is ignored (tie 0); E loads every cycle.
// STRUCTURE
//  ctrl_pipe_pkg: condition-code localparams (COND_EQ..COND_AL), flag bit indices (FLAG_N..FLAG_V),
//    RW code constants.
//  Sub-module ctrl_cond_check: combinational cond + NZCV -> pass. Stage chain built with generate.
// TESTING
//  1 Reset mid-stream: assert reset with E,M,W full -> all outputs 0 same cycle, flagsE=0.
//  2 CMP sets Z (flag_write=11, alu_flagsE=01000, no_write=1), then BEQ next cycle
//    -> branch_takenE=1, reg_writeM=00 for CMP.
//  3 ADDNE with Z=1, reg_write=01, pc_write=1 -> reg_writeM=00, pc_srcW=0 after N_POST cycles;
//    pc_wr_pendingF high until it leaves W.
//  4 flushE with SMULL (reg_write=11) in D -> next cycle validE=0, flags unchanged, reg_writeM=00.
//  5 N_POST=4: single MOV (reg_write=01, AL) -> reg_writeW=01 exactly 4 cycles after E.
//  6 STALL_EN: stallE=1 for 2 cycles under STR -> ctrlE held, mem_writeM=0 twice, then 1 once.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-propagation pipeline: condition codes,
// NZCV bit positions and register-write codes.
package ctrl_pipe_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   // Bit positions inside the NZCV nibble (the top four bits of the flags register)
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_32   = 2'b01;
   localparam logic [1:0] RW_64   = 2'b11;

   // Single-bit side-effect controls carried down the post-E chain
   typedef struct packed {
      logic mem_write;
      logic pc_write;
      logic pc_src;
   } side_t;

endpackage

// File: rtl/ctrl_pipe_gen_if.sv
// Decode-side inputs and pipeline-state outputs of ctrl_pipe_gen.
// master = decoder/hazard side, slave = the pipeline.
interface ctrl_pipe_gen_if #(
   parameter int CTRL_W = 8,
   parameter int RW_W   = 2,
   parameter int FLAG_W = 5
);
   logic              validD;
   logic [CTRL_W-1:0] ctrlD;
   logic [RW_W-1:0]   reg_writeD;
   logic              mem_writeD;
   logic              branchD;
   logic              pc_writeD;
   logic              no_writeD;
   logic [1:0]        flag_writeD;
   logic [3:0]        condD;
   logic [FLAG_W-1:0] alu_flagsE;
   logic              flushE;
   logic              stallE;

   logic [CTRL_W-1:0] ctrlE;
   logic              cond_exE;
   logic              branch_takenE;
   logic [FLAG_W-1:0] flagsE;
   logic [CTRL_W-1:0] ctrlM;
   logic [CTRL_W-1:0] ctrlW;
   logic [RW_W-1:0]   reg_writeM;
   logic [RW_W-1:0]   reg_writeW;
   logic              mem_writeM;
   logic              pc_srcW;
   logic              pc_wr_pendingF;

   modport master (
      output validD, ctrlD, reg_writeD, mem_writeD, branchD, pc_writeD, no_writeD,
             flag_writeD, condD, alu_flagsE, flushE, stallE,
      input  ctrlE, cond_exE, branch_takenE, flagsE, ctrlM, ctrlW, reg_writeM,
             reg_writeW, mem_writeM, pc_srcW, pc_wr_pendingF
   );

   modport slave (
      input  validD, ctrlD, reg_writeD, mem_writeD, branchD, pc_writeD, no_writeD,
             flag_writeD, condD, alu_flagsE, flushE, stallE,
      output ctrlE, cond_exE, branch_takenE, flagsE, ctrlM, ctrlW, reg_writeM,
             reg_writeW, mem_writeM, pc_srcW, pc_wr_pendingF
   );
endinterface

// File: rtl/ctrl_cond_check.sv
// Combinational ARM condition evaluation: 4-bit condition + NZCV -> pass.
module ctrl_cond_check
   import ctrl_pipe_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_pass
);
   logic w_n, w_z, w_c, w_v;
   assign w_n = i_nzcv[FLAG_N];
   assign w_z = i_nzcv[FLAG_Z];
   assign w_c = i_nzcv[FLAG_C];
   assign w_v = i_nzcv[FLAG_V];

   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = ~w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = ~w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = ~w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = ~w_v;
         COND_HI: o_pass = w_c & ~w_z;
         COND_LS: o_pass = ~w_c | w_z;
         COND_GE: o_pass = (w_n == w_v);
         COND_LT: o_pass = (w_n != w_v);
         COND_GT: o_pass = ~w_z & (w_n == w_v);
         COND_LE: o_pass = w_z | (w_n != w_v);
         COND_AL, COND_NV: o_pass = 1'b1;
      endcase
   end
endmodule

// File: rtl/ctrl_pipe_gen.sv
// Control-propagation pipeline D->E->stage 1..N_POST with E-stage condition
// evaluation and flags update. Optional hold of E via macro CTRL_PIPE_STALL_EN.
module ctrl_pipe_gen
   import ctrl_pipe_pkg::*;
#(
   parameter int CTRL_W = 8,
   parameter int RW_W   = 2,
   parameter int FLAG_W = 5,
   parameter int N_POST = 2
) (
   input  logic             clk,
   input  logic             reset,
   ctrl_pipe_gen_if.slave   bus
);
   logic              r_validE, r_memwE, r_brE, r_pcwE, r_nowE;
   logic [CTRL_W-1:0] r_ctrlE;
   logic [RW_W-1:0]   r_rwE;
   logic [1:0]        r_fwE;
   logic [3:0]        r_condE;
   logic [FLAG_W-1:0] r_flags;
   logic              w_stall, w_pass, w_cond_ex;

`ifdef CTRL_PIPE_STALL_EN
   assign w_stall = bus.stallE;
`else
   logic w_unused_stall;
   assign w_unused_stall = bus.stallE;
   assign w_stall        = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_validE <= 1'b0; r_ctrlE <= '0; r_rwE <= '0; r_memwE <= 1'b0; r_brE <= 1'b0;
         r_pcwE <= 1'b0; r_nowE <= 1'b0; r_fwE <= '0; r_condE <= '0;
      end else if (bus.flushE) begin
         r_validE <= 1'b0; r_ctrlE <= '0; r_rwE <= '0; r_memwE <= 1'b0; r_brE <= 1'b0;
         r_pcwE <= 1'b0; r_nowE <= 1'b0; r_fwE <= '0; r_condE <= '0;
      end else if (!w_stall) begin
         r_validE <= bus.validD;    r_ctrlE <= bus.ctrlD;     r_rwE <= bus.reg_writeD;
         r_memwE  <= bus.mem_writeD; r_brE  <= bus.branchD;   r_pcwE <= bus.pc_writeD;
         r_nowE   <= bus.no_writeD;  r_fwE  <= bus.flag_writeD; r_condE <= bus.condD;
      end
   end

   ctrl_cond_check u_cond (
      .i_cond (r_condE),
      .i_nzcv (r_flags[FLAG_W-1 -: 4]),
      .o_pass (w_pass)
   );

   assign w_cond_ex = r_validE & w_pass & ~w_stall;

   // flag_write[1] covers N,Z; flag_write[0] covers C,V and every extended bit below V
   logic [FLAG_W-1:0] w_fmask;
   always_comb begin
      w_fmask = '0;
      if (r_fwE[1]) w_fmask[FLAG_W-1 -: 2] = 2'b11;
      if (r_fwE[0]) w_fmask[FLAG_W-3:0]    = '1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_flags <= '0;
      else if (w_cond_ex) r_flags <= (r_flags & ~w_fmask) | (bus.alu_flagsE & w_fmask);
   end

   // Index 0 is the gated stage-1 input; index s is the output of stage s
   logic [N_POST:0]             w_vld_pipe;
   logic [N_POST:0][CTRL_W-1:0] w_ctrl_pipe;
   logic [N_POST:0][RW_W-1:0]   w_rw_pipe;
   side_t [N_POST:0]            w_side_pipe;

   assign w_vld_pipe[0]            = r_validE & ~w_stall;
   assign w_ctrl_pipe[0]           = w_stall ? '0 : r_ctrlE;
   assign w_rw_pipe[0]             = (w_cond_ex & ~r_nowE) ? r_rwE : RW_W'(RW_NONE);
   assign w_side_pipe[0].mem_write = r_memwE & w_cond_ex;
   assign w_side_pipe[0].pc_write  = r_pcwE & ~w_stall;
   assign w_side_pipe[0].pc_src    = r_pcwE & w_cond_ex;

   for (genvar s = 1; s <= N_POST; s++) begin : g_stage
      logic              r_vld;
      logic [CTRL_W-1:0] r_ctrl;
      logic [RW_W-1:0]   r_rw;
      side_t             r_side;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_vld <= 1'b0; r_ctrl <= '0; r_rw <= '0; r_side <= '0;
         end else begin
            r_vld  <= w_vld_pipe[s-1];
            r_ctrl <= w_ctrl_pipe[s-1];
            r_rw   <= w_rw_pipe[s-1];
            r_side <= w_side_pipe[s-1];
         end
      end
      assign w_vld_pipe[s]  = r_vld;
      assign w_ctrl_pipe[s] = r_ctrl;
      assign w_rw_pipe[s]   = r_rw;
      assign w_side_pipe[s] = r_side;
   end

   // Pending PC write counts the raw pc_write of every valid instruction, taken or not
   logic w_pend;
   always_comb begin
      w_pend = (bus.validD & bus.pc_writeD) | (r_validE & r_pcwE);
      for (int s = 1; s <= N_POST; s++)
         w_pend = w_pend | (w_vld_pipe[s] & w_side_pipe[s].pc_write);
   end

   logic w_unused_tail;
   assign w_unused_tail = w_side_pipe[N_POST].mem_write;

   assign bus.ctrlE          = r_ctrlE;
   assign bus.cond_exE       = w_cond_ex;
   assign bus.branch_takenE  = r_brE & w_cond_ex;
   assign bus.flagsE         = r_flags;
   assign bus.ctrlM          = w_ctrl_pipe[1];
   assign bus.reg_writeM     = w_rw_pipe[1];
   assign bus.mem_writeM     = w_side_pipe[1].mem_write;
   assign bus.ctrlW          = w_ctrl_pipe[N_POST];
   assign bus.reg_writeW     = w_rw_pipe[N_POST];
   assign bus.pc_srcW        = w_side_pipe[N_POST].pc_src;
   assign bus.pc_wr_pendingF = ~reset & w_pend;

endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// Directed bench for ctrl_pipe_gen: condition table plus hand sequences,
// with an N_POST=2 and an N_POST=4 instance driven in lockstep.
module tb_ctrl_pipe_gen;
   import ctrl_pipe_pkg::*;

   localparam int CW = 8, RWW = 2, FW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ctrl_pipe_gen_if #(.CTRL_W(CW), .RW_W(RWW), .FLAG_W(FW)) bus2 ();
   ctrl_pipe_gen_if #(.CTRL_W(CW), .RW_W(RWW), .FLAG_W(FW)) bus4 ();

   ctrl_pipe_gen #(.CTRL_W(CW), .RW_W(RWW), .FLAG_W(FW), .N_POST(2)) dut2 (
      .clk(clk), .reset(rst), .bus(bus2.slave));
   ctrl_pipe_gen #(.CTRL_W(CW), .RW_W(RWW), .FLAG_W(FW), .N_POST(4)) dut4 (
      .clk(clk), .reset(rst), .bus(bus4.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic setd(input logic v, input logic [CW-1:0] c, input logic [RWW-1:0] rw,
                       input logic mw, input logic br, input logic pcw, input logic nw,
                       input logic [1:0] fw, input logic [3:0] cd);
      bus2.validD = v;  bus2.ctrlD = c;  bus2.reg_writeD = rw; bus2.mem_writeD = mw;
      bus2.branchD = br; bus2.pc_writeD = pcw; bus2.no_writeD = nw;
      bus2.flag_writeD = fw; bus2.condD = cd;
      bus4.validD = v;  bus4.ctrlD = c;  bus4.reg_writeD = rw; bus4.mem_writeD = mw;
      bus4.branchD = br; bus4.pc_writeD = pcw; bus4.no_writeD = nw;
      bus4.flag_writeD = fw; bus4.condD = cd;
   endtask

   task automatic idle;
      setd(1'b0, '0, RW_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, COND_AL);
   endtask

   task automatic setx(input logic fl, input logic st, input logic [FW-1:0] alu);
      bus2.flushE = fl; bus2.stallE = st; bus2.alu_flagsE = alu;
      bus4.flushE = fl; bus4.stallE = st; bus4.alu_flagsE = alu;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [FW-1:0] alu;
      logic [3:0]    cond;
      logic          pass;
   } vec_t;

   vec_t tbl [19];

   initial begin
      // {alu flags N Z C V Q, condition, expected pass}
      tbl[0]  = '{5'b01000, COND_EQ, 1'b1};
      tbl[1]  = '{5'b00001, COND_EQ, 1'b0};
      tbl[2]  = '{5'b01000, COND_NE, 1'b0};
      tbl[3]  = '{5'b00100, COND_CS, 1'b1};
      tbl[4]  = '{5'b00000, COND_CC, 1'b1};
      tbl[5]  = '{5'b10000, COND_MI, 1'b1};
      tbl[6]  = '{5'b10001, COND_PL, 1'b0};
      tbl[7]  = '{5'b00010, COND_VS, 1'b1};
      tbl[8]  = '{5'b00100, COND_HI, 1'b1};
      tbl[9]  = '{5'b01100, COND_HI, 1'b0};
      tbl[10] = '{5'b01100, COND_LS, 1'b1};
      tbl[11] = '{5'b10010, COND_GE, 1'b1};
      tbl[12] = '{5'b10000, COND_LT, 1'b1};
      tbl[13] = '{5'b00000, COND_GT, 1'b1};
      tbl[14] = '{5'b11000, COND_GT, 1'b0};
      tbl[15] = '{5'b10000, COND_LE, 1'b1};
      tbl[16] = '{5'b00001, COND_AL, 1'b1};
      tbl[17] = '{5'b00000, COND_NV, 1'b1};
      tbl[18] = '{5'b00010, COND_VC, 1'b0};

      // Reset state, with a pending-PC instruction sitting in D
      rst = 1'b1;
      setd(1'b1, 8'hFF, RW_32, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, COND_AL);
      setx(1'b0, 1'b0, '0);
      @(negedge clk);
      chk("rst_ctrlE", bus2.ctrlE, 0);
      chk("rst_flagsE", bus2.flagsE, 0);
      chk("rst_cond_exE", bus2.cond_exE, 0);
      chk("rst_pending", bus2.pc_wr_pendingF, 0);
      idle;
      rst = 1'b0;

      // Flag writer followed immediately by a conditional branch on the new flags
      for (int i = 0; i < 19; i++) begin
         setd(1'b1, 8'h10, RW_32, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, COND_AL);
         tick;
         setd(1'b1, 8'h20, RW_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, tbl[i].cond);
         setx(1'b0, 1'b0, tbl[i].alu);
         tick;
         setx(1'b0, 1'b0, '0);
         idle;
         @(negedge clk);
         chk($sformatf("tbl%0d_flagsE", i), bus2.flagsE, tbl[i].alu);
         chk($sformatf("tbl%0d_cond_exE", i), bus2.cond_exE, tbl[i].pass);
         chk($sformatf("tbl%0d_branch", i), bus2.branch_takenE, tbl[i].pass);
      end

      // CMP sets Z, BEQ next cycle
      setd(1'b1, 8'h31, RW_32, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, COND_AL);
      tick;
      setd(1'b1, 8'h32, RW_NONE, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, COND_EQ);
      setx(1'b0, 1'b0, 5'b01000);
      tick;
      setx(1'b0, 1'b0, '0);
      // ADDNE with Z=1 enters D
      setd(1'b1, 8'h41, RW_32, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, COND_NE);
      @(negedge clk);
      chk("cmp_branch_taken", bus2.branch_takenE, 1);
      chk("cmp_reg_writeM", bus2.reg_writeM, RW_NONE);
      chk("cmp_ctrlM", bus2.ctrlM, 8'h31);
      chk("cmp_flagsE", bus2.flagsE, 5'b01000);
      chk("addne_pend_D", bus2.pc_wr_pendingF, 1);
      tick;
      idle;
      @(negedge clk);
      chk("addne_cond_exE", bus2.cond_exE, 0);
      chk("addne_pend_E", bus2.pc_wr_pendingF, 1);
      tick;
      @(negedge clk);
      chk("addne_reg_writeM", bus2.reg_writeM, RW_NONE);
      chk("addne_pend_M", bus2.pc_wr_pendingF, 1);
      tick;
      @(negedge clk);
      chk("addne_pc_srcW", bus2.pc_srcW, 0);
      chk("addne_reg_writeW", bus2.reg_writeW, RW_NONE);
      chk("addne_pend_W", bus2.pc_wr_pendingF, 1);
      tick;
      @(negedge clk);
      chk("addne_pend_gone", bus2.pc_wr_pendingF, 0);
      chk("addne_pend4_s3", bus4.pc_wr_pendingF, 1);

      // flushE with SMULL in D
      setd(1'b1, 8'h55, RW_64, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, COND_AL);
      setx(1'b1, 1'b0, '0);
      tick;
      idle;
      setx(1'b0, 1'b0, 5'b11111);
      @(negedge clk);
      chk("flush_ctrlE", bus2.ctrlE, 0);
      chk("flush_cond_exE", bus2.cond_exE, 0);
      tick;
      setx(1'b0, 1'b0, '0);
      @(negedge clk);
      chk("flush_flagsE", bus2.flagsE, 5'b01000);
      chk("flush_reg_writeM", bus2.reg_writeM, RW_NONE);
      chk("flush_ctrlM", bus2.ctrlM, 0);

      // Single MOV: W latency 2 on dut2, 4 on dut4
      tick;
      tick;
      setd(1'b1, 8'hA5, RW_32, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, COND_AL);
      tick;
      idle;
      for (int k = 1; k <= 5; k++) begin
         tick;
         @(negedge clk);
         chk($sformatf("mov4_rwW_k%0d", k), bus4.reg_writeW, (k == 4) ? RW_32 : RW_NONE);
         chk($sformatf("mov2_rwW_k%0d", k), bus2.reg_writeW, (k == 2) ? RW_32 : RW_NONE);
         if (k == 4) chk("mov4_ctrlW", bus4.ctrlW, 8'hA5);
      end

      // STR under stallE
      setd(1'b1, 8'h3C, RW_NONE, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, COND_AL);
      tick;
      setd(1'b1, 8'h77, RW_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, COND_AL);
      setx(1'b0, 1'b1, '0);
`ifdef CTRL_PIPE_STALL_EN
      @(negedge clk);
      chk("stall_cond_exE", bus2.cond_exE, 0);
      chk("stall_ctrlE0", bus2.ctrlE, 8'h3C);
      tick;
      @(negedge clk);
      chk("stall_memM1", bus2.mem_writeM, 0);
      chk("stall_ctrlE1", bus2.ctrlE, 8'h3C);
      tick;
      setx(1'b0, 1'b0, '0);
      @(negedge clk);
      chk("stall_memM2", bus2.mem_writeM, 0);
      chk("stall_ctrlE2", bus2.ctrlE, 8'h3C);
      tick;
      idle;
      @(negedge clk);
      chk("stall_memM3", bus2.mem_writeM, 1);
      chk("stall_ctrlE3", bus2.ctrlE, 8'h77);
      tick;
      @(negedge clk);
      chk("stall_memM4", bus2.mem_writeM, 0);
`else
      @(negedge clk);
      chk("nostall_cond_exE", bus2.cond_exE, 1);
      tick;
      setx(1'b0, 1'b0, '0);
      idle;
      @(negedge clk);
      chk("nostall_memM", bus2.mem_writeM, 1);
      chk("nostall_ctrlE", bus2.ctrlE, 8'h77);
`endif

      // Reset mid-stream with E, M and W all occupied
      setd(1'b1, 8'h61, RW_32, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, COND_AL);
      tick;
      setd(1'b1, 8'h62, RW_32, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, COND_AL);
      tick;
      setd(1'b1, 8'h63, RW_32, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, COND_AL);
      tick;
      @(negedge clk);
      chk("pre_rst_ctrlW", bus2.ctrlW, 8'h61);
      chk("pre_rst_pending", bus2.pc_wr_pendingF, 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_ctrlE", bus2.ctrlE, 0);
      chk("mid_rst_ctrlM", bus2.ctrlM, 0);
      chk("mid_rst_ctrlW", bus2.ctrlW, 0);
      chk("mid_rst_rwM", bus2.reg_writeM, 0);
      chk("mid_rst_rwW", bus2.reg_writeW, 0);
      chk("mid_rst_flagsE", bus2.flagsE, 0);
      chk("mid_rst_cond_exE", bus2.cond_exE, 0);
      chk("mid_rst_pending", bus2.pc_wr_pendingF, 0);
      chk("mid_rst_ctrlW4", bus4.ctrlW, 0);
      idle;
      @(negedge clk);
      rst = 1'b0;
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
